equiv_stim_gen: RTL and testbench
=================================

# equiv_stim_gen

Stimulus driver and verdict collector for the equivalence-checking harness. It generates a reproducible pseudo-random input vector stream on `wire0`..`wire4` and feeds it to both design copies. It compares their 91-bit outputs `y_1`/`y_2` with a configurable output latency and reports a pass/fail verdict with a saturating mismatch count. It sits on the driving side of the harness, and its outputs connect directly to the harness top-level inputs.

## Interface
- `NUM_VEC`, 1024: vectors per run, 1..2^32-1.
- `LAT`, 1: design output latency in cycles, 0..15.
- `SEED`, 32'hACE10001: default seed, used when `seed_i` is zero at start.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a run. Sampled only in IDLE.
- `seed_i` in 32: run seed, sampled with `start`.
- `y_1` in 91: output of copy 1.
- `y_2` in 91: output of copy 2.
- `wire0` out 12, `wire1` out 20, `wire2` out 22, `wire3` out 19, `wire4` out 21: stimulus outputs.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle pulse when the verdict is valid.
- `pass` out 1: verdict; 1 when zero mismatches.
- `mismatch_cnt` out 16: mismatching compare cycles, saturates at 16'hFFFF.
- `first_fail_idx` out 32: present only under the config macro.
- `first_fail_vec` out 94: present only under the config macro.

## Operation
- **PRNG:** xorshift32, `xs(x) = x^=x<<13; x^=x>>17; x^=x<<5`.
  - `x0` is `seed_i`, or `SEED` if `seed_i` is 0.
  - If the result is still 0, `x0` is 32'h1.
  - `x(n+1) = xs(x(n))`.
- **History register:** a 96-bit `hist` holds `{x(k+2), x(k+1), x(k)}` for vector k.
  - On start it loads `{xs(xs(x0)), xs(x0), x0}`.
  - Each RUN cycle it shifts: `hist <= {xs(hist[95:64]), hist[95:32]}`.
- **Stimulus mapping:** `stim = hist[93:0]`.
  - `wire0 = stim[11:0]`
  - `wire1 = stim[31:12]`
  - `wire2 = stim[53:32]`
  - `wire3 = stim[72:54]`
  - `wire4 = stim[93:73]`
- **States:**
  - IDLE: on `start`, go to RUN, clear `mismatch_cnt`, clear `pass`, load `hist`.
  - RUN: lasts `NUM_VEC` cycles. Vector k is driven during RUN cycle k. Then go to DRAIN, or straight to DONE if `LAT` is 0.
  - DRAIN: lasts `LAT` cycles. Stimulus holds the last vector.
  - DONE: lasts one cycle, with `done`=1 and `pass` = (`mismatch_cnt`==0). Then go to IDLE.
- **Compare window:** a compare happens at elapsed cycle c (counted from RUN cycle 0) when `LAT` <= c < `NUM_VEC`+`LAT`. That compare is attributed to vector c-`LAT`.
  - Mismatch means `y_1 != y_2`, over the full 91 bits.
  - Each mismatch increments `mismatch_cnt`, saturating.
  - Exactly `NUM_VEC` compares happen per run.
- **Start handling:** `start` is ignored outside IDLE. A `start` held high in IDLE on the cycle after DONE begins a new run.
- **Verdict hold:** `pass` and `mismatch_cnt` hold from DONE until the next accepted `start`.

## Timing
- Reset values: all outputs 0, state IDLE, `hist` 0.
- Stimulus outputs are 0 in IDLE and DONE, and hold the last vector in DRAIN.
- The first vector is visible on the cycle after `start` is sampled.
- `done` asserts `NUM_VEC`+`LAT`+1 cycles after `start` is sampled.
- Compare uses `y_1`/`y_2` sampled at the rising edge ending cycle c. The count update is visible the next cycle.
- Reset mid-run: next cycle is IDLE, outputs zero, `pass`=0, no `done` pulse.
- Counters: the vector/elapsed counter is 33 bits, so there is no wrap at `NUM_VEC`+`LAT` = 2^32+14.

## Configuration
- Macro: `EQUIV_STIM_FAIL_CAPTURE_EN`.
- Defined:
  - On the first mismatch of a run, latch `first_fail_idx` = vector index and `first_fail_vec` = the stimulus of that vector.
  - This needs a `LAT`-deep stimulus delay line.
  - Both values are cleared on start and hold until the next start.
- Undefined:
  - Neither port exists, and there is no delay line.
  - All other behaviour is identical.

## Test plan
- **Seed 1, `NUM_VEC`=4, `LAT`=1, `y_2`=`y_1`:** vector 0 gives `wire0`=12'h001, `wire1`=0, `wire2`=22'h042021. Then `done` at cycle 6, `pass`=1, `mismatch_cnt`=0.
- **`seed_i`=0, `SEED`=0:** `x0`=1, so the stream is identical to the seed-1 case.
- **`y_2` bit 90 flipped at elapsed cycle 6, `LAT`=1, `NUM_VEC`=16:** `mismatch_cnt`=1 and `pass`=0. With the macro, `first_fail_idx`=5 and `first_fail_vec`=vector 5.
- **`y_2`=~`y_1` throughout, `NUM_VEC`=70000:** `mismatch_cnt`=16'hFFFF (saturated), `pass`=0.
- **`LAT`=0, `NUM_VEC`=3:** no DRAIN, `done` 4 cycles after start. A `start` pulse during RUN has no effect.
- **`rst_n` low at RUN cycle 2:** next cycle all outputs 0 and `busy`=0. A new start reproduces vector 0 exactly.

Source files
------------

// File: rtl/equiv_stim_gen_if.sv
// Handshake and data bundle between the equivalence stimulus generator and the harness.
// Under EQUIV_STIM_FAIL_CAPTURE_EN the bundle also carries the first-failure capture outputs.
interface equiv_stim_gen_if;
   logic        start;
   logic [31:0] seed_i;
   logic [90:0] y_1;
   logic [90:0] y_2;
   logic [11:0] wire0;
   logic [19:0] wire1;
   logic [21:0] wire2;
   logic [18:0] wire3;
   logic [20:0] wire4;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] mismatch_cnt;
`ifdef EQUIV_STIM_FAIL_CAPTURE_EN
   logic [31:0] first_fail_idx;
   logic [93:0] first_fail_vec;

   modport master (
      input  start, seed_i, y_1, y_2,
      output wire0, wire1, wire2, wire3, wire4,
      output busy, done, pass, mismatch_cnt, first_fail_idx, first_fail_vec
   );
   modport slave (
      output start, seed_i, y_1, y_2,
      input  wire0, wire1, wire2, wire3, wire4,
      input  busy, done, pass, mismatch_cnt, first_fail_idx, first_fail_vec
   );
`else
   modport master (
      input  start, seed_i, y_1, y_2,
      output wire0, wire1, wire2, wire3, wire4,
      output busy, done, pass, mismatch_cnt
   );
   modport slave (
      output start, seed_i, y_1, y_2,
      input  wire0, wire1, wire2, wire3, wire4,
      input  busy, done, pass, mismatch_cnt
   );
`endif
endinterface

// File: rtl/equiv_stim_gen.sv
// Xorshift32 stimulus driver and y_1/y_2 verdict collector for the equivalence harness.
// Optional first-failure capture (index + stimulus) is enabled by EQUIV_STIM_FAIL_CAPTURE_EN.
module equiv_stim_gen #(
   parameter int unsigned NUM_VEC = 1024,
   parameter int unsigned LAT     = 1,
   parameter logic [31:0] SEED    = 32'hACE10001
) (
   input  logic             clk,
   input  logic             rst_n,
   equiv_stim_gen_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [32:0] LAT_X      = 33'(LAT);
   localparam logic [32:0] RUN_LAST   = 33'(NUM_VEC) - 33'd1;
   localparam logic [32:0] DRAIN_LAST = 33'(NUM_VEC) + 33'(LAT) - 33'd1;
   localparam logic [31:0] SEED_EFF   = (SEED != 32'd0) ? SEED : 32'd1;

   function automatic logic [31:0] xs(input logic [31:0] a);
      logic [31:0] x;
      x = a;
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return x;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t      state;
   logic [95:0] hist;
   logic [32:0] cnt;
   logic [15:0] mm_cnt;
   logic        pass_q;
   logic        done_q;
   logic        busy_q;

   logic [31:0] x0;
   logic        active;
   logic        cmp_en;
   logic        mism;
   logic        fin;
   logic [15:0] mm_nxt;

   always_comb begin
      x0     = (bus.seed_i != 32'd0) ? bus.seed_i : SEED_EFF;
      active = (state == RUN) || (state == DRAIN);
      cmp_en = active && (cnt >= LAT_X);
      mism   = (bus.y_1 != bus.y_2);
      fin    = active && (cnt == DRAIN_LAST);
      mm_nxt = (cmp_en && mism) ? sat_inc(mm_cnt) : mm_cnt;
   end

   // Control/sequencing stage: stimulus history, elapsed counter and verdict
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         hist   <= '0;
         cnt    <= '0;
         mm_cnt <= '0;
         pass_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         mm_cnt <= mm_nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
                  hist   <= {xs(xs(x0)), xs(x0), x0};
                  cnt    <= '0;
                  mm_cnt <= '0;
                  pass_q <= 1'b0;
               end
            end
            RUN: begin
               cnt <= cnt + 33'd1;
               // The last vector stays on the outputs throughout DRAIN.
               if (cnt == RUN_LAST) state <= DRAIN;
               else                 hist  <= {xs(hist[95:64]), hist[95:32]};
            end
            DRAIN: cnt <= cnt + 33'd1;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
         if (fin) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (mm_nxt == 16'd0);
            hist   <= '0;
         end
      end
   end

   assign bus.wire0        = hist[11:0];
   assign bus.wire1        = hist[31:12];
   assign bus.wire2        = hist[53:32];
   assign bus.wire3        = hist[72:54];
   assign bus.wire4        = hist[93:73];
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.mismatch_cnt = mm_cnt;

`ifdef EQUIV_STIM_FAIL_CAPTURE_EN
   localparam int unsigned DL_D   = (LAT == 0) ? 1 : LAT;
   localparam int unsigned DL_SEL = (LAT == 0) ? 0 : LAT - 1;

   logic [93:0] dl_p0 [DL_D];
   logic [93:0] fail_src;
   logic [31:0] ff_idx;
   logic [93:0] ff_vec;

   // Delay stage: stimulus lined up with the design output it produced
   always_ff @(posedge clk) begin
      if (active) begin
         dl_p0[0] <= hist[93:0];
         for (int j = 1; j < int'(DL_D); j++) dl_p0[j] <= dl_p0[j-1];
      end
   end

   assign fail_src = (LAT == 0) ? hist[93:0] : dl_p0[DL_SEL];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff_idx <= '0;
         ff_vec <= '0;
      end else if (state == IDLE && bus.start) begin
         ff_idx <= '0;
         ff_vec <= '0;
      end else if (cmp_en && mism && mm_cnt == 16'd0) begin
         ff_idx <= 32'(cnt - LAT_X);
         ff_vec <= fail_src;
      end
   end

   assign bus.first_fail_idx = ff_idx;
   assign bus.first_fail_vec = ff_vec;
`endif

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Bench for equiv_stim_gen: several parameterisations driven from a table, random runs
// and hand-written corner sequences, checked against a spec-level xorshift/verdict model.
`timescale 1ns/1ps
module tb_equiv_stim_gen;
   localparam int NI = 5;

   function automatic int nv_f(input int g);
      case (g)
         0, 1:    return 4;
         2:       return 16;
         3:       return 3;
         default: return 70000;
      endcase
   endfunction

   function automatic int lt_f(input int g);
      case (g)
         3:       return 0;
         4:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] sd_f(input int g);
      return (g == 1) ? 32'h0 : 32'hACE10001;
   endfunction

   function automatic logic [31:0] xs(input logic [31:0] a);
      logic [31:0] x;
      x = a;
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return x;
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        st [NI];
   logic [31:0] sd;
   logic [90:0] y1, y2;
   logic [93:0] wv [NI];
   logic        bz [NI];
   logic        dn [NI];
   logic        ps [NI];
   logic [15:0] mc [NI];
`ifdef EQUIV_STIM_FAIL_CAPTURE_EN
   logic [31:0] ffi [NI];
   logic [93:0] ffv [NI];
`endif

   int checks = 0;
   int failures = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      equiv_stim_gen_if bus ();
      assign bus.start  = st[g];
      assign bus.seed_i = sd;
      assign bus.y_1    = y1;
      assign bus.y_2    = y2;
      assign wv[g] = {bus.wire4, bus.wire3, bus.wire2, bus.wire1, bus.wire0};
      assign bz[g] = bus.busy;
      assign dn[g] = bus.done;
      assign ps[g] = bus.pass;
      assign mc[g] = bus.mismatch_cnt;
`ifdef EQUIV_STIM_FAIL_CAPTURE_EN
      assign ffi[g] = bus.first_fail_idx;
      assign ffv[g] = bus.first_fail_vec;
`endif
      equiv_stim_gen #(.NUM_VEC(nv_f(g)), .LAT(lt_f(g)), .SEED(sd_f(g))) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic rand_y();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      y1 = r[90:0];
      y2 = y1;
   endtask

   // mode: 0 none, 1 random, 2 all inverted, 3 mask per vector (always mismatch outside window), 4 bit 90 at flip_c
   task automatic run(input int i, input logic [31:0] seed, input int mode, input logic [15:0] mmask,
                      input int flip_c, input bit mid_start,
                      output logic [93:0] v0, output logic [15:0] fcnt, output logic fpass);
      logic [31:0] xq [$];
      logic [31:0] x;
      logic [95:0] t;
      logic [93:0] ev;
      logic [15:0] ecnt;
      logic [93:0] ffvec;
      logic [31:0] ffidx;
      bit          ffhit;
      bit          mm;
      int          n, l, k;
      n = nv_f(i);
      l = lt_f(i);
      x = (seed != 32'd0) ? seed : sd_f(i);
      if (x == 32'd0) x = 32'd1;
      xq = {};
      for (int j = 0; j < n + 2; j++) begin
         xq.push_back(x);
         x = xs(x);
      end
      ecnt = '0; ffhit = 1'b0; ffidx = '0; ffvec = '0; v0 = '0;
      @(posedge clk); #1;
      st[i] = 1'b1; sd = seed;
      @(posedge clk); #1;
      st[i] = 1'b0;
      for (int c = 0; c <= n + l; c++) begin
         rand_y();
         case (mode)
            0:       mm = 1'b0;
            1:       mm = ($urandom_range(0, 3) == 0);
            2:       mm = 1'b1;
            3:       mm = (c >= l && c < n + l) ? mmask[c-l] : 1'b1;
            default: mm = (c == flip_c);
         endcase
         if (mm) begin
            if (mode == 2)      y2 = ~y1;
            else if (mode == 4) y2 = y1 ^ (91'd1 << 90);
            else                y2 = y1 ^ (91'd1 << $urandom_range(0, 90));
         end
         if (mid_start && c == 1) begin st[i] = 1'b1; sd = 32'h1234; end
         if (mid_start && c == 2) st[i] = 1'b0;
         @(negedge clk);
         k = (c < n) ? c : n - 1;
         t = {xq[k+2], xq[k+1], xq[k]};
         ev = (c < n + l) ? t[93:0] : '0;
         if (c == 0) v0 = wv[i];
         chk("stim", 128'(wv[i]), 128'(ev));
         chk("busy", 128'(bz[i]), 128'(c < n + l));
         chk("done", 128'(dn[i]), 128'(c == n + l));
         chk("mismatch_cnt", 128'(mc[i]), 128'(ecnt));
         chk("pass", 128'(ps[i]), 128'((c == n + l) && (ecnt == 16'd0)));
`ifdef EQUIV_STIM_FAIL_CAPTURE_EN
         if (c == n + l) begin
            chk("first_fail_idx", 128'(ffi[i]), 128'(ffidx));
            chk("first_fail_vec", 128'(ffv[i]), 128'(ffvec));
         end
`endif
         if (mm && c >= l && c < n + l) begin
            if (!ffhit) begin
               ffhit = 1'b1;
               ffidx = 32'(c - l);
               t = {xq[c-l+2], xq[c-l+1], xq[c-l]};
               ffvec = t[93:0];
            end
            if (ecnt != 16'hFFFF) ecnt++;
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("hold_cnt", 128'(mc[i]), 128'(ecnt));
      chk("hold_pass", 128'(ps[i]), 128'(ecnt == 16'd0));
      chk("idle_busy_done", 128'({bz[i], dn[i]}), 128'(0));
      chk("idle_stim", 128'(wv[i]), 128'(0));
      fcnt = mc[i];
      fpass = ps[i];
   endtask

   typedef struct {
      logic [31:0] seed;
      logic [15:0] mm;
      logic [15:0] cnt;
      logic        pass;
      logic [53:0] v0lo;
      logic [53:0] msk;
   } row_t;

   row_t        tbl [5];
   logic [93:0] v0;
   logic [15:0] fc;
   logic        fp;
   logic [31:0] xa [3];
   logic [95:0] tt;
   logic [93:0] ev;
   bit          seen;

   initial begin
      tbl[0] = '{32'h1, 16'h0, 16'd0, 1'b1, {22'h042021, 32'h1}, {54{1'b1}}};
      tbl[1] = '{32'h2, 16'h5, 16'd2, 1'b0, {22'h084042, 32'h2}, {54{1'b1}}};
      tbl[2] = '{32'h3, 16'h8, 16'd1, 1'b0, {22'h0C6063, 32'h3}, {54{1'b1}}};
      tbl[3] = '{32'h0, 16'hF, 16'd4, 1'b0, {22'h0, 32'hACE10001}, {22'h0, 32'hFFFFFFFF}};
      tbl[4] = '{32'h1, 16'h6, 16'd2, 1'b0, {22'h042021, 32'h1}, {54{1'b1}}};
      for (int i = 0; i < NI; i++) st[i] = 1'b0;
      sd = '0; y1 = '0; y2 = '0;

      // Reset values on every instance
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_stim", 128'(wv[i]), 128'(0));
         chk("rst_flags", 128'({bz[i], dn[i], ps[i]}), 128'(0));
         chk("rst_cnt", 128'(mc[i]), 128'(0));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int r = 0; r < 5; r++) begin
         run(0, tbl[r].seed, 3, tbl[r].mm, 0, 1'b0, v0, fc, fp);
         chk("tbl_v0", 128'(v0[53:0] & tbl[r].msk), 128'(tbl[r].v0lo));
         chk("tbl_cnt", 128'(fc), 128'(tbl[r].cnt));
         chk("tbl_pass", 128'(fp), 128'(tbl[r].pass));
      end

      // SEED=0 with seed_i=0 falls back to x0=1
      run(1, 32'h0, 0, 16'h0, 0, 1'b0, v0, fc, fp);
      chk("seed0_v0", 128'(v0[53:0]), 128'({22'h042021, 32'h1}));
      chk("seed0_pass", 128'(fp), 128'(1));

      // Single bit-90 flip at elapsed cycle 6
      run(2, 32'h1, 4, 16'h0, 6, 1'b0, v0, fc, fp);
      chk("flip_cnt", 128'(fc), 128'(1));
      chk("flip_pass", 128'(fp), 128'(0));
`ifdef EQUIV_STIM_FAIL_CAPTURE_EN
      chk("flip_idx", 128'(ffi[2]), 128'(5));
`endif

      for (int r = 0; r < 6; r++) run(2, $urandom, 1, 16'h0, 0, 1'b0, v0, fc, fp);

      // LAT=0: no DRAIN, start during RUN ignored
      run(3, 32'h1, 1, 16'h0, 0, 1'b1, v0, fc, fp);
      chk("lat0_v0", 128'(v0[53:0]), 128'({22'h042021, 32'h1}));

      // Start held high across DONE starts the next run from IDLE
      xa[0] = 32'h1; xa[1] = xs(xa[0]); xa[2] = xs(xa[1]);
      @(posedge clk); #1;
      st[3] = 1'b1; sd = 32'h1;
      y1 = '0; y2 = '0;
      @(posedge clk); #1;
      for (int c = 0; c <= 8; c++) begin
         if (c == 5) st[3] = 1'b0;
         @(negedge clk);
         chk("held_busy", 128'(bz[3]), 128'((c < 3) || (c >= 5 && c < 8)));
         chk("held_done", 128'(dn[3]), 128'((c == 3) || (c == 8)));
         if (c == 0 || c == 5) begin
            tt = {xa[2], xa[1], xa[0]};
            chk("held_v0", 128'(wv[3]), 128'(tt[93:0]));
         end
         if (c == 4) chk("held_idle_stim", 128'(wv[3]), 128'(0));
         @(posedge clk); #1;
      end

      // Saturation with outputs always different
      run(4, 32'h5, 2, 16'h0, 0, 1'b0, v0, fc, fp);
      chk("sat_cnt", 128'(fc), 128'(16'hFFFF));
      chk("sat_pass", 128'(fp), 128'(0));

      // Reset at RUN cycle 2, then a fresh run reproduces vector 0
      @(posedge clk); #1;
      st[0] = 1'b1; sd = 32'h1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      y1 = '0; y2 = '1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      tt = {xs(xs(xs(xs(32'h1)))), xs(xs(xs(32'h1))), xs(xs(32'h1))};
      ev = tt[93:0];
      chk("pre_rst_stim", 128'(wv[0]), 128'(ev));
      chk("pre_rst_cnt", 128'(mc[0]), 128'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      y2 = '0;
      @(negedge clk);
      chk("mid_rst_stim", 128'(wv[0]), 128'(0));
      chk("mid_rst_flags", 128'({bz[0], dn[0], ps[0]}), 128'(0));
      chk("mid_rst_cnt", 128'(mc[0]), 128'(0));
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (dn[0]) seen = 1'b1;
      end
      chk("mid_rst_no_done", 128'(seen), 128'(0));
      run(0, 32'h1, 0, 16'h0, 0, 1'b0, v0, fc, fp);
      chk("post_rst_v0", 128'(v0[53:0]), 128'({22'h042021, 32'h1}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
